// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub ops plus multi-cycle shift-add MUL and restoring DIV.
// The MUL/DIV datapath is built only when the macro SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic             err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       op_r;
  logic             pend;
  logic             accept, multi, run_done;

  logic [WIDTH-1:0] s_y, s_hi;
  logic             s_cf, s_err;
  logic             fin_valid, fin_cf, fin_err;
  logic [WIDTH-1:0] fin_y, fin_hi;

  assign accept = start && (state == IDLE);

`ifdef SEQ_ALU_MULDIV_EN
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] w_hi, w_lo, n_hi, n_lo;
  logic [WIDTH:0]   sum, trial, diff;

  // DIV by zero never iterates; it completes through the single-cycle path.
  assign multi    = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign run_done = (state == RUN) && (count == LAST);

  // One iteration: MUL shifts {carry+hi, lo} right; DIV shifts {rem, quot} left and trial-subtracts.
  always_comb begin
    sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, a_r} : '0);
    trial = {w_hi, w_lo[WIDTH-1]};
    diff  = trial - {1'b0, b_r};
    if (op_r == OP_MUL) begin
      {n_hi, n_lo} = {sum, w_lo[WIDTH-1:1]};
    end else if (trial >= {1'b0, b_r}) begin
      n_hi = diff[WIDTH-1:0];
      n_lo = {w_lo[WIDTH-2:0], 1'b1};
    end else begin
      n_hi = trial[WIDTH-1:0];
      n_lo = {w_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      w_hi  <= '0;
      w_lo  <= '0;
      busy  <= 1'b0;
    end else if (accept && multi) begin
      count <= '0;
      w_hi  <= '0;
      w_lo  <= (op == OP_DIV) ? a : b;
    end else if (state == RUN) begin
      if (!run_done) begin
        w_hi  <= n_hi;
        w_lo  <= n_lo;
        count <= count + 1'b1;
        busy  <= 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end
`else
  assign multi    = 1'b0;
  assign run_done = 1'b0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && multi) next_state = RUN;
      RUN:     if (run_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle results, computed from the operands latched at acceptance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    s_y   = '0;
    s_hi  = '0;
    s_cf  = 1'b0;
    s_err = 1'b0;
    case (op_r)
      OP_ADD: {s_cf, s_y} = {1'b0, a_r} + {1'b0, b_r};
      OP_SUB: {s_cf, s_y} = {1'b0, a_r} - {1'b0, b_r};
      OP_MUL: s_err = 1'b1;
      OP_DIV: begin
`ifdef SEQ_ALU_MULDIV_EN
        s_y  = '1;
        s_hi = a_r;
`endif
        s_err = 1'b1;
      end
      OP_AND: s_y = a_r & b_r;
      OP_OR:  s_y = a_r | b_r;
      OP_NOT: s_y = ~a_r;
      OP_XOR: s_y = a_r ^ b_r;
      default: s_y = '0;
    endcase
  end

  always_comb begin
    fin_valid = pend;
    fin_y     = s_y;
    fin_hi    = s_hi;
    fin_cf    = s_cf;
    fin_err   = s_err;
`ifdef SEQ_ALU_MULDIV_EN
    // After WIDTH iterations both MUL and DIV leave the low/quotient word in w_lo.
    if (run_done) begin
      fin_valid = 1'b1;
      fin_y     = w_lo;
      fin_hi    = w_hi;
      fin_cf    = 1'b0;
      fin_err   = 1'b0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      pend  <= 1'b0;
      y     <= '0;
      hi    <= '0;
      done  <= 1'b0;
      zf    <= 1'b1;
      cf    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      pend  <= accept && !multi;
      done  <= fin_valid;
      if (accept) begin
        a_r  <= a;
        b_r  <= b;
        op_r <= op;
      end
      if (fin_valid) begin
        y   <= fin_y;
        hi  <= fin_hi;
        zf  <= (fin_y == '0);
        cf  <= fin_cf;
        err <= fin_err;
      end
    end
  end

endmodule
